// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: one expansion round per clock, eleven
// round keys held in a register file, one-cycle registered read port.
// Also holds the rcon and subByte helper modules used by the datapath.

// Round constant: Rcon byte in bits [31:24] for rounds 1..10, zero otherwise.
module rcon (
  input  logic [3:0]  round,
  output logic [31:0] rc
);
  // Lookup of the round-constant byte
  always_comb begin
    rc = 32'h0;
    case (round)
      4'd1:    rc = 32'h0100_0000;
      4'd2:    rc = 32'h0200_0000;
      4'd3:    rc = 32'h0400_0000;
      4'd4:    rc = 32'h0800_0000;
      4'd5:    rc = 32'h1000_0000;
      4'd6:    rc = 32'h2000_0000;
      4'd7:    rc = 32'h4000_0000;
      4'd8:    rc = 32'h8000_0000;
      4'd9:    rc = 32'h1b00_0000;
      4'd10:   rc = 32'h3600_0000;
      default: rc = 32'h0;
    endcase
  end
endmodule

// AES S-box applied to each byte of a 32-bit word. The S-box is built from
// the GF(2^8) inverse (a^254) followed by the affine map, instead of a table.
module subByte (
  input  logic [31:0] x,
  output logic [31:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gf_mul(a, a);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign y = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
endmodule

module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_done,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [3:0]   rcnt;
  logic [127:0] k [0:10];

  // Handshake: a key transfers on a rising edge where key_valid && key_ready.
  // key_ready depends only on state (IDLE or DONE), never on key_valid, and
  // key_in is captured on that edge so the source may drop it afterwards.
  logic accept;
  assign key_ready = (state == IDLE) || (state == DONE);
  assign busy      = (state == EXPAND);
  assign accept    = key_valid && key_ready;
  assign state_dbg = state;

  // Expansion datapath: combinational from the previous round key
  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [31:0]  rot_w, sub_w, rc_w, temp;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [127:0] next_key;

  assign prev_idx = rcnt - 4'd1;
  assign prev_key = (prev_idx <= 4'd10) ? k[prev_idx] : 128'h0;
  assign rot_w    = {prev_key[23:0], prev_key[31:24]};

  subByte u_sub (.x(rot_w), .y(sub_w));
  rcon    u_rcon (.round(rcnt), .rc(rc_w));

  assign temp     = sub_w ^ rc_w;
  assign w0n      = prev_key[127:96] ^ temp;
  assign w1n      = prev_key[95:64]  ^ w0n;
  assign w2n      = prev_key[63:32]  ^ w1n;
  assign w3n      = prev_key[31:0]   ^ w2n;
  assign next_key = {w0n, w1n, w2n, w3n};

  // Single write port: k[0] on accept, k[rcnt] on every expansion edge
  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [127:0] wr_data;

  assign wr_en   = accept || (state == EXPAND);
  assign wr_idx  = accept ? 4'd0 : rcnt;
  assign wr_data = accept ? key_in : next_key;

  // Read path: a key written on this same edge is forwarded to the output
  logic         rd_in_range, rd_hit, rd_ok;
  logic [127:0] rd_data;

  assign rd_in_range = (rk_idx <= 4'd10);
  assign rd_hit      = wr_en && (wr_idx == rk_idx);
  assign rd_data     = !rd_in_range ? 128'h0 :
                       rd_hit       ? wr_data : k[rk_idx];
  assign rd_ok       = rd_in_range &&
                       ((state == DONE) ||
                        ((state == EXPAND) && (rk_idx < rcnt)) ||
                        rd_hit);

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXPAND;
      EXPAND:  if (rcnt == 4'd10) state_next = DONE;
      DONE:    if (accept) state_next = EXPAND;
      default: state_next = IDLE;
    endcase
  end

  // State, round counter, key storage and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rcnt      <= 4'd0;
      keys_done <= 1'b0;
      rk_out    <= 128'h0;
      rk_valid  <= 1'b0;
      for (int i = 0; i <= 10; i++) k[i] <= 128'h0;
    end else begin
      state <= state_next;
      if (wr_en && (wr_idx <= 4'd10)) k[wr_idx] <= wr_data;
      if (accept) begin
        rcnt      <= 4'd1;
        keys_done <= 1'b0;
      end else if (state == EXPAND) begin
        rcnt <= rcnt + 4'd1;
        if (rcnt == 4'd10) keys_done <= 1'b1;
      end
      rk_out   <= rd_data;
      rk_valid <= rd_ok;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: directed cycles push expected status and
// read-port values into a queue; a monitor on the falling edge pops and
// compares them one cycle later.
module tb_aes_key_sched_ctrl;

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic [1:0]   state_dbg;

  aes_key_sched_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .keys_done (keys_done),
    .rk_idx    (rk_idx),
    .rk_out    (rk_out),
    .rk_valid  (rk_valid),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {key_ready, busy, keys_done}
  localparam logic [2:0] IDL = 3'b100;
  localparam logic [2:0] EXP = 3'b010;
  localparam logic [2:0] DN  = 3'b101;

  // Expected item: {status[2:0], rk_valid, rk_out[127:0]}
  logic [131:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [127:0] fk [0:10];
  logic [127:0] z1, z10;

  // Monitor: checks DUT outputs after the edge each item was queued for
  always @(negedge clk) begin
    logic [131:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({key_ready, busy, keys_done} !== e[131:129]) begin
        bad++;
        $display("FAIL status t=%0t got rdy/busy/done=%b want %b",
                 $time, {key_ready, busy, keys_done}, e[131:129]);
      end
      total++;
      if ({rk_valid, rk_out} !== e[128:0]) begin
        bad++;
        $display("FAIL read t=%0t got valid=%b data=%h want valid=%b data=%h",
                 $time, rk_valid, rk_out, e[128], e[127:0]);
      end
    end
  end

  // Driver: one clock cycle of stimulus plus its expected outcome
  task automatic cyc(input logic r, input logic kv, input logic [127:0] kin,
                     input logic [3:0] idx, input logic [2:0] st,
                     input logic rv, input logic [127:0] d);
    @(negedge clk);
    #1;
    rst       = r;
    key_valid = kv;
    key_in    = kin;
    rk_idx    = idx;
    exp_q.push_back({st, rv, d});
  endtask

  initial begin
    fk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    z1     = 128'h62636363626363636263636362636363;
    z10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_idx = '0;

    // Reset and idle
    cyc(1, 0, '0, 4'd0, IDL, 0, '0);
    cyc(1, 0, '0, 4'd0, IDL, 0, '0);
    cyc(0, 0, '0, 4'd3, IDL, 0, '0);

    // FIPS key, reading idx n on edge En (same-edge forwarding)
    cyc(0, 1, fk[0], 4'd0, EXP, 1, fk[0]);
    for (int n = 1; n <= 10; n++)
      cyc(0, 0, '0, 4'(n), (n == 10) ? DN : EXP, 1, fk[n]);

    // Reads in DONE, including out-of-range indices
    cyc(0, 0, '0, 4'd1,  DN, 1, fk[1]);
    cyc(0, 0, '0, 4'd2,  DN, 1, fk[2]);
    cyc(0, 0, '0, 4'd10, DN, 1, fk[10]);
    cyc(0, 0, '0, 4'd11, DN, 0, '0);
    cyc(0, 0, '0, 4'd15, DN, 0, '0);
    cyc(0, 0, '0, 4'd5,  DN, 1, fk[5]);

    // All-zero key accepted in DONE; keys_done drops on the accept edge
    cyc(0, 1, '0, 4'd0, EXP, 1, '0);
    // key_valid held with a different key during EXPAND: ignored.
    // Reading one index ahead of the writer: stale FIPS key, not valid.
    for (int n = 1; n <= 9; n++)
      cyc(0, 1, fk[0], 4'(n + 1), EXP, 0, fk[n + 1]);
    cyc(0, 1, fk[0], 4'd10, DN, 1, z10);
    // First DONE cycle accepts the held key; old zero-key k1 still valid
    cyc(0, 1, fk[0], 4'd1, EXP, 1, z1);
    for (int m = 1; m <= 4; m++)
      cyc(0, 0, '0, 4'(m), EXP, 1, fk[m]);

    // Reset on E5 abandons the expansion
    cyc(1, 0, '0, 4'd5, IDL, 0, '0);
    for (int i = 0; i <= 10; i++)
      cyc(0, 0, '0, 4'(i), IDL, 0, '0);

    // Reload FIPS key, reading ahead of the writer (cleared, not valid)
    cyc(0, 1, fk[0], 4'd1, EXP, 0, '0);
    for (int n = 1; n <= 9; n++)
      cyc(0, 0, '0, 4'(n + 1), EXP, 0, '0);
    cyc(0, 0, '0, 4'd11, DN, 0, '0);
    for (int i = 0; i <= 10; i++)
      cyc(0, 0, '0, 4'(i), DN, 1, fk[i]);

    // Drain the scoreboard
    repeat (3) @(negedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative AES-128 key-schedule controller. It accepts a 128-bit cipher key through a valid/ready handshake and runs the key-expansion datapath one round per clock for 10 rounds, storing all 11 round keys in an internal register file. The cipher core reads any round key by index through a registered port. The block sits between the key-load interface and the encrypt/decrypt round pipeline, and it reuses the existing `subByte` (32-bit) and `rcon` (4-bit round in, 32-bit constant out) modules.

## Interface
- No parameters. The block is fixed to AES-128: Nk=4, 10 rounds.
- `clk` in 1: single clock. All state updates occur on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in 128: cipher key. Word w0 = `key_in[127:96]`, w3 = `key_in[31:0]`.
- `key_valid` in 1: `key_in` is valid.
- `key_ready` out 1: block can accept a key. High in IDLE and DONE.
- `busy` out 1: high in EXPAND.
- `keys_done` out 1: all 11 round keys are stored and stable.
- `rk_idx` in 4: round-key read index, 0..10.
- `rk_out` out 128: registered round key for the `rk_idx` sampled on the previous edge.
- `rk_valid` out 1: registered. High when the sampled index refers to an already-computed key.

## Operation
- States: IDLE, EXPAND, DONE. The round counter `rcnt` is 4 bits wide.
- IDLE → EXPAND on `key_valid && key_ready`. On that edge: k[0] ← `key_in`, `rcnt` ← 1.
- EXPAND, each edge:
  - temp = SubWord(RotWord(k[rcnt-1].w3)) ^ Rcon(rcnt). RotWord(x) = {x[23:0], x[31:24]}. The Rcon byte occupies bits [31:24].
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - k[rcnt] ← {w0', w1', w2', w3'}; `rcnt` ← `rcnt` + 1.
  - On the edge that writes k[10]: transition to DONE and set `keys_done`.
- The datapath is purely combinational from k[rcnt-1]. There is exactly one `subByte` and one `rcon` instance, indexed by `rcnt`.
- DONE holds all keys indefinitely. A new handshake in DONE clears `keys_done`, writes the new k[0] and re-enters EXPAND. Old k[1..10] remain readable with `rk_valid=0` until each is overwritten.
- `key_valid` is ignored during EXPAND (`key_ready=0`). `key_in` does not need to be held after the accept edge.
- Read port, every edge:
  - `rk_out` ← k[`rk_idx`] if `rk_idx` ≤ 10, else 0.
  - `rk_valid` ← (`rk_idx` ≤ 10) && (DONE, or EXPAND with `rk_idx` < `rcnt`, or the index was written on this same edge).
- Reset has priority over everything. State ← IDLE, `rcnt` ← 0, all k[i] ← 0, `rk_out` ← 0, `rk_valid` ← 0, `keys_done` ← 0. Reset mid-EXPAND abandons the expansion, and no partial key remains readable as valid.

## Timing
- Reset values: `key_ready`=1 (IDLE), `busy`=0, `keys_done`=0, `rk_out`=0, `rk_valid`=0.
- Define the accept edge as E0. k[n] is written on edge En, for n = 1..10.
- `keys_done`=1 and `busy`=0 after E10, which is 10 cycles after the accept edge. `key_ready` also returns to 1 after E10.
- `busy`=1 from after E0 through E9 (10 cycles).
- Read latency is 1 cycle. Back-to-back reads with a different index every cycle are supported.
- When `rk_idx`=n is sampled on edge En, the newly written k[n] is forwarded to `rk_out` with `rk_valid`=1.
- Throughput is one key expansion per 11 cycles, including the accept cycle, when a new key is offered immediately in DONE.

## Test plan
- FIPS-197 key: load `2b7e151628aed2a6abf7158809cf4f3c` → `keys_done` rises exactly 10 cycles after accept. Reads then return:
  - idx 1 = `a0fafe1788542cb123a339392a6c7605`
  - idx 2 = `f2c295f27a96b9435935807a7359f67f`
  - idx 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`
  - each with `rk_valid`=1, one cycle after the index is applied.
- Read during expansion: sweep `rk_idx` 0..10 every cycle from the accept edge → `rk_valid`=1 only for indices already written (including same-edge forwarding). Values match the vector.
- Handshake: hold `key_valid`=1 with a different `key_in` throughout EXPAND → ignored, `key_ready`=0. Accepted on the first cycle in DONE, and `keys_done` drops on that edge.
- Reset at E5 mid-expansion → next cycle in IDLE, `keys_done`=0, `rk_out`=0, and every index read gives `rk_valid`=0. A subsequent load of the FIPS key produces correct round keys.
- Out-of-range index: `rk_idx`=11 and 15 in DONE → `rk_out`=0, `rk_valid`=0.
- All-zero key → idx 1 = `62636363626363636263636362636363`, idx 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
